// File: rtl/xif_result_queue.sv
// FIFO that buffers FPU results for the core-side result interface, with a
// per-id kill table so results of killed instructions are consumed and dropped.
module xif_result_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [X_ID_WIDTH-1:0]     in_id,
    input  logic [XLEN-1:0]           in_data,
    input  logic [4:0]                in_rd,
    input  logic                      in_we,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [X_ID_WIDTH-1:0]     out_id,
    output logic [XLEN-1:0]           out_data,
    output logic [4:0]                out_rd,
    output logic                      out_we,
    input  logic                      commit_valid,
    input  logic [X_ID_WIDTH-1:0]     commit_id,
    input  logic                      commit_kill,
    output logic [$clog2(DEPTH):0]    count,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned NID = 1 << X_ID_WIDTH;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       data;
        logic [4:0]            rd;
        logic                  we;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [NID-1:0]   kill_q, kill_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             accept;
    logic             kill_hit;
    logic             push;
    logic             drop;
    logic             pop;

    // Handshake status depends only on registered occupancy.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    // A kill issued in the same cycle as the result still catches it.
    assign kill_hit  = kill_q[in_id] || (commit_valid && commit_kill && (commit_id == in_id));
    assign push      = accept && !kill_hit;
    assign drop      = accept && kill_hit;
    assign pop       = out_valid && out_ready;

    assign head     = mem_q[rptr_q];
    assign out_id   = head.id;
    assign out_data = head.data;
    assign out_rd   = head.rd;
    assign out_we   = head.we;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;

    // Next-state for pointers, occupancy, kill table and drop counter.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        kill_d     = kill_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The drop consumes the kill, so its clear is applied after the commit update.
        if (commit_valid) kill_d[commit_id] = commit_kill;
        if (drop)         kill_d[in_id]     = 1'b0;

        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            kill_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            kill_q     <= kill_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset; it is only observed while out_valid is high.
    always_ff @(posedge ck) begin
        if (push) begin
            mem_q[wptr_q] <= '{id: in_id, data: in_data, rd: in_rd, we: in_we};
        end
    end

endmodule

// File: tb/tb_xif_result_queue.sv
// Directed bench for xif_result_queue: ordering, backpressure, kill/drop and reset.
module tb_xif_result_queue;

    logic        ck;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_id;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    int total;
    int bad;

    xif_result_queue #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
        .ck           (ck),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_id        (in_id),
        .in_data      (in_data),
        .in_rd        (in_rd),
        .in_we        (in_we),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .count        (count),
        .drop_cnt     (drop_cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge ck);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_id        = '0;
        in_data      = '0;
        in_rd        = '0;
        in_we        = 1'b0;
        out_ready    = 1'b0;
        commit_valid = 1'b0;
        commit_id    = '0;
        commit_kill  = 1'b0;

        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
        cycle();
        rst = 1'b1;

        // Three results, core stalled; first push on the first edge after reset.
        in_valid = 1'b1; in_id = 4'd1; in_data = 32'h11; in_rd = 5'd1; in_we = 1'b1;
        check("no_bypass", 64'(out_valid), 64'd0);
        cycle();
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_id",    64'(out_id),    64'd1);
        in_id = 4'd2; in_data = 32'h22; in_rd = 5'd2;
        cycle();
        in_id = 4'd3; in_data = 32'h33; in_rd = 5'd3; in_we = 1'b0;
        cycle();
        in_valid = 1'b0;
        check("q3_count", 64'(count),    64'd3);
        check("q3_id",    64'(out_id),   64'd1);
        check("q3_data",  64'(out_data), 64'h11);
        check("q3_rd",    64'(out_rd),   64'd1);

        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("drain3_id",   64'(out_id),   64'(i));
            check("drain3_data", 64'(out_data), 64'(i * 32'h11));
            cycle();
        end
        out_ready = 1'b0;
        check("drain3_empty", 64'(out_valid), 64'd0);
        check("drain3_count", 64'(count),     64'd0);

        // Fill to full, hold backpressure, then stream across the pointer wrap.
        in_valid = 1'b1; in_we = 1'b1;
        for (int id = 5; id <= 8; id++) begin
            in_id = 4'(id); in_data = 32'(id * 16); in_rd = 5'(id);
            cycle();
        end
        check("full_count",    64'(count),    64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_id = 4'd9; in_data = 32'h90; in_rd = 5'd9;
        cycle();
        check("full_hold_count", 64'(count),  64'd4);
        check("full_head",       64'(out_id), 64'd5);
        out_ready = 1'b1;
        cycle();
        check("full_pop_count", 64'(count),    64'd3);
        check("full_pop_ready", 64'(in_ready), 64'd1);
        for (int id = 9; id <= 12; id++) begin
            in_id = 4'(id); in_data = 32'(id * 16); in_rd = 5'(id);
            check("stream_id", 64'(out_id), 64'(id - 3));
            cycle();
        end
        in_valid = 1'b0;
        check("stream_count", 64'(count), 64'd3);
        for (int id = 10; id <= 12; id++) begin
            check("stream_tail_id",   64'(out_id),   64'(id));
            check("stream_tail_data", 64'(out_data), 64'(id * 16));
            cycle();
        end
        out_ready = 1'b0;
        check("stream_empty", 64'(count), 64'd0);

        // Steady push+pop at occupancy 2.
        in_valid = 1'b1;
        in_id = 4'd0; in_data = 32'h200; cycle();
        in_id = 4'd1; in_data = 32'h201; cycle();
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            in_id = 4'(k); in_data = 32'h200 + 32'(k);
            cycle();
            check("steady_count", 64'(count),    64'd2);
            check("steady_data",  64'(out_data), 64'h200 + 64'(k - 1));
        end
        in_valid = 1'b0;
        cycle(); cycle();
        out_ready = 1'b0;
        check("steady_empty", 64'(count),    64'd0);
        check("steady_drops", 64'(drop_cnt), 64'd0);

        // Kill id 7 first, then its result arrives and is dropped.
        commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 4'd7;
        cycle();
        commit_valid = 1'b0;
        in_valid = 1'b1; in_id = 4'd7; in_data = 32'h70;
        cycle();
        check("kill7_count", 64'(count),     64'd0);
        check("kill7_valid", 64'(out_valid), 64'd0);
        check("kill7_drop",  64'(drop_cnt),  64'd1);
        in_data = 32'h77;
        cycle();
        in_valid = 1'b0;
        check("kill7_again_count", 64'(count),    64'd1);
        check("kill7_again_id",    64'(out_id),   64'd7);
        check("kill7_again_data",  64'(out_data), 64'h77);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // A kill after enqueue leaves the entry; a commit clears the flag.
        in_valid = 1'b1; in_id = 4'd4; in_data = 32'h44; cycle();
        in_valid = 1'b0;
        commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 4'd4; cycle();
        check("late_kill_count", 64'(count),  64'd1);
        check("late_kill_id",    64'(out_id), 64'd4);
        commit_kill = 1'b0; cycle();
        commit_valid = 1'b0;
        in_valid = 1'b1; in_id = 4'd4; in_data = 32'h45; cycle();
        in_valid = 1'b0;
        check("commit_clr_count", 64'(count),    64'd2);
        check("commit_clr_drop",  64'(drop_cnt), 64'd1);
        out_ready = 1'b1;
        check("commit_clr_d0", 64'(out_data), 64'h44); cycle();
        check("commit_clr_d1", 64'(out_data), 64'h45); cycle();
        out_ready = 1'b0;

        // Same-cycle kill and result on id 3 with one entry already queued.
        in_valid = 1'b1; in_id = 4'd1; in_data = 32'hA1; cycle();
        in_id = 4'd3; in_data = 32'h30;
        commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 4'd3;
        cycle();
        in_valid = 1'b0; commit_valid = 1'b0;
        check("same_kill_count", 64'(count),    64'd1);
        check("same_kill_drop",  64'(drop_cnt), 64'd2);
        in_valid = 1'b1; in_id = 4'd3; in_data = 32'h33; cycle();
        in_valid = 1'b0;
        check("same_kill_reuse", 64'(count), 64'd2);
        out_ready = 1'b1;
        check("same_kill_h0", 64'(out_data), 64'hA1); cycle();
        check("same_kill_h1", 64'(out_data), 64'h33); cycle();
        out_ready = 1'b0;

        // Drop of id 10 alongside a fresh kill of id 11.
        commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 4'd10; cycle();
        in_valid = 1'b1; in_id = 4'd10; commit_id = 4'd11; cycle();
        commit_valid = 1'b0;
        check("dual_drop_cnt", 64'(drop_cnt), 64'd3);
        in_id = 4'd11; cycle();
        check("dual_kill11_cnt",   64'(drop_cnt), 64'd4);
        check("dual_kill11_count", 64'(count),    64'd0);
        in_id = 4'd10; in_data = 32'hAA; cycle();
        in_valid = 1'b0;
        check("dual_id10_count", 64'(count),    64'd1);
        check("dual_id10_data",  64'(out_data), 64'hAA);
        out_ready = 1'b1; cycle(); out_ready = 1'b0;

        // Drop counter saturates at 255.
        in_valid = 1'b1; in_id = 4'd5;
        commit_valid = 1'b1; commit_kill = 1'b1; commit_id = 4'd5;
        repeat (260) cycle();
        in_valid = 1'b0; commit_valid = 1'b0;
        check("sat_drop",  64'(drop_cnt), 64'd255);
        check("sat_count", 64'(count),    64'd0);

        // Asynchronous reset with three entries stored.
        in_valid = 1'b1; in_we = 1'b1;
        in_id = 4'd1; cycle();
        in_id = 4'd2; cycle();
        in_id = 4'd3; cycle();
        in_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count),     64'd0);
        check("async_rst_ready", 64'(in_ready),  64'd1);
        check("async_rst_drop",  64'(drop_cnt),  64'd0);
        cycle();
        rst = 1'b1;
        in_valid = 1'b1; in_id = 4'd6; in_data = 32'h66;
        cycle();
        in_valid = 1'b0;
        check("post_rst_count", 64'(count),    64'd1);
        check("post_rst_id",    64'(out_id),   64'd6);
        check("post_rst_data",  64'(out_data), 64'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xif_result_queue.md
XIF_RESULT_QUEUE -- requirements
Module: xif_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-002 SHALL have parameter X_ID_WIDTH, default 4, instruction id width.
REQ-003 SHALL have parameter XLEN, default 32, result data width.
REQ-004 SHALL have port ck  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  FPU result valid.
REQ-007 SHALL have port in_ready  output  1  queue can accept a result.
REQ-008 SHALL have port in_id / in_data / in_rd / in_we  input  X_ID_WIDTH / XLEN / 5 / 1  FPU result fields.
REQ-009 SHALL have port out_valid  output  1  core-side result valid.
REQ-010 SHALL have port out_ready  input  1  core accepts result.
REQ-011 SHALL have port out_id / out_data / out_rd / out_we  output  X_ID_WIDTH / XLEN / 5 / 1  head-entry fields.
REQ-012 SHALL have port commit_valid  input  1  commit strobe from core.
REQ-013 SHALL have port commit_id  input  X_ID_WIDTH  committed/killed id.
REQ-014 SHALL have port commit_kill  input  1  1 = kill, 0 = commit.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port drop_cnt  output  8  saturating count of dropped killed results.

Function
REQ-017 Push SHALL occur on rising edge when in_valid && in_ready and the id is not killed (REQ-024).
REQ-018 Pop SHALL occur on rising edge when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count < DEPTH), from registered state only; no dependence on out_ready.
REQ-020 out_valid SHALL equal (count != 0); out_* SHALL be driven from the head storage entry.
REQ-021 Latency: a result pushed at edge N SHALL appear on out_* after edge N (one cycle) when queue was empty; no same-cycle in-to-out bypass.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order; full + pop gives no push that cycle (in_ready=0).
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-024 Kill table: one flag per id (2^X_ID_WIDTH); commit_valid && commit_kill SHALL set flag[commit_id]; commit_valid && !commit_kill SHALL clear it.
REQ-025 Handshake with in_valid && in_ready where flag[in_id]=1, or commit_valid && commit_kill && commit_id==in_id same cycle, SHALL be consumed but not enqueued, SHALL clear flag[in_id], SHALL increment drop_cnt (saturate at 255).
REQ-026 Same-cycle drop and new commit_kill on a different id SHALL both take effect.
REQ-027 Entries already enqueued SHALL NOT be removed by a later kill.
REQ-028 Results with in_we=0 SHALL be enqueued normally (completion still reported).
REQ-029 Pop with count==0 and push with count==DEPTH SHALL be impossible by construction.

Reset
REQ-030 On rst low, asynchronously: pointers, count, all kill flags, drop_cnt SHALL be 0; out_valid=0, in_ready=1.
REQ-031 Reset mid-operation SHALL discard all stored entries; out_data value while out_valid=0 is don't-care.
REQ-032 First push SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 Push ids 1,2,3 with data 0x11,0x22,0x33, out_ready=0 -> count=3, out_id=1, out_data=0x11.
REQ-034 Fill 4 entries, hold in_valid -> in_ready=0, count=4; one pop -> in_ready=1 next cycle, FIFO order kept across wrap (ids 5..12 streamed, out ids 5..12).
REQ-035 Steady push+pop every cycle at count=2 -> count stays 2, no drops.
REQ-036 commit kill id 7, then result id 7 -> not output, drop_cnt=1, flag cleared; next result id 7 is enqueued.
REQ-037 commit kill id 3 in same cycle as result id 3 -> dropped, drop_cnt increments, count unchanged.
REQ-038 Assert rst low with count=3 -> out_valid=0, count=0, in_ready=1 immediately.
